eth_mac_loopback_sim: RTL

ETH_MAC_LOOPBACK_SIM -- requirements
Module: eth_mac_loopback_sim

---
 rtl/eth_mac_loopback_sim_if.sv | 17 +
 rtl/eth_mac_loopback_sim.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_loopback_sim_if.sv
// AXI-Stream style beat bundle shared by the loopback TX sink and RX source.
`timescale 1ns/1ps
interface eth_mac_loopback_sim_if #(
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/eth_mac_loopback_sim.sv
// Simulation MAC loopback: buffers whole TX frames and replays them on RX.
// Statistics counters are built only when ETH_SIM_STATS_EN is defined.
`timescale 1ns/1ps
module eth_mac_loopback_sim #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned IFG_CYCLES = 2
) (
  input  logic                        eth_clk,
  input  logic                        sys_rst,
  eth_mac_loopback_sim_if.slave       s_axis_tx,
  eth_mac_loopback_sim_if.master      m_axis_rx,
  output logic                        overflow_sticky,
  output logic [31:0]                 tx_frame_cnt,
  output logic [31:0]                 rx_frame_cnt,
  output logic [31:0]                 drop_frame_cnt,
  output logic [31:0]                 tx_byte_cnt
);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned ENT_W  = DATA_W + KEEP_W + 2;
  localparam int unsigned IFG_W  = $clog2(IFG_CYCLES + 2);

  typedef enum logic [1:0] {TX_ACCEPT, TX_DROP, TX_GAP} tx_state_t;
  typedef enum logic {RX_IDLE, RX_SEND} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [PW-1:0]    wr_ptr, rd_ptr, commit_ptr, frame_start;
  logic [IFG_W-1:0] ifg_cnt;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] rd_entry_c;

  logic [DATA_W-1:0] rx_data_q;
  logic [KEEP_W-1:0] rx_keep_q;
  logic              rx_last_q;
  logic              rx_user_q;

  logic accept_c, full_c, rx_avail_c;
  logic do_write, do_commit, do_rewind, do_drop_frame, frame_end;

  assign s_axis_tx.tready = ~sys_rst & (tx_state != TX_GAP);
  assign accept_c   = s_axis_tx.tvalid & s_axis_tx.tready;
  // Fullness uses the pre-read pointers, so a same-cycle read never frees space early.
  assign full_c     = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
  assign rx_avail_c = rd_ptr != commit_ptr;
  assign rd_entry_c = mem[rd_ptr[AW-1:0]];

  assign m_axis_rx.tvalid = (rx_state == RX_SEND);
  assign m_axis_rx.tdata  = rx_data_q;
  assign m_axis_rx.tkeep  = rx_keep_q;
  assign m_axis_rx.tlast  = rx_last_q;
  assign m_axis_rx.tuser  = rx_user_q;

  // TX next-state and write/commit/drop decisions
  always_comb begin
    tx_next       = tx_state;
    do_write      = 1'b0;
    do_commit     = 1'b0;
    do_rewind     = 1'b0;
    do_drop_frame = 1'b0;
    case (tx_state)
      TX_ACCEPT: begin
        if (accept_c) begin
          if (full_c) begin
            do_rewind     = 1'b1;
            do_drop_frame = s_axis_tx.tlast;
            if (!s_axis_tx.tlast) tx_next = TX_DROP;
          end else begin
            do_write  = 1'b1;
            do_commit = s_axis_tx.tlast;
          end
        end
      end
      TX_DROP:  if (accept_c && s_axis_tx.tlast) do_drop_frame = 1'b1;
      TX_GAP:   if (ifg_cnt == '0) tx_next = TX_ACCEPT;
      default:  tx_next = TX_ACCEPT;
    endcase
    frame_end = do_commit | do_drop_frame;
    if (frame_end) tx_next = (IFG_CYCLES != 0) ? TX_GAP : TX_ACCEPT;
  end

  // RX streams whenever committed beats exist; committed frames are whole, so no intra-frame gaps
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (rx_avail_c) rx_next = RX_SEND;
      RX_SEND: if (!rx_avail_c) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= {s_axis_tx.tdata, s_axis_tx.tkeep,
                                          s_axis_tx.tlast, s_axis_tx.tuser};
  end

  always_ff @(posedge eth_clk) begin
    if (sys_rst) begin
      tx_state        <= TX_ACCEPT;
      rx_state        <= RX_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      commit_ptr      <= '0;
      frame_start     <= '0;
      ifg_cnt         <= '0;
      overflow_sticky <= 1'b0;
      rx_data_q       <= '0;
      rx_keep_q       <= '0;
      rx_last_q       <= 1'b0;
      rx_user_q       <= 1'b0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      if (do_write)  wr_ptr <= wr_ptr + PW'(1);
      if (do_rewind) begin
        wr_ptr          <= frame_start;
        overflow_sticky <= 1'b1;
      end
      if (do_commit) begin
        commit_ptr  <= wr_ptr + PW'(1);
        frame_start <= wr_ptr + PW'(1);
      end
      if (frame_end)                              ifg_cnt <= IFG_W'(IFG_CYCLES) - IFG_W'(1);
      else if (tx_state == TX_GAP && ifg_cnt != '0) ifg_cnt <= ifg_cnt - IFG_W'(1);
      if (rx_avail_c) begin
        rd_ptr    <= rd_ptr + PW'(1);
        rx_data_q <= rd_entry_c[ENT_W-1 -: DATA_W];
        rx_keep_q <= rd_entry_c[KEEP_W+1:2];
        rx_last_q <= rd_entry_c[1];
        rx_user_q <= rd_entry_c[1] & rd_entry_c[0];
      end else begin
        rx_data_q <= '0;
        rx_keep_q <= '0;
        rx_last_q <= 1'b0;
        rx_user_q <= 1'b0;
      end
    end
  end

`ifdef ETH_SIM_STATS_EN
  logic [31:0] frame_bytes;

  function automatic logic [31:0] keep_bytes(input logic [KEEP_W-1:0] k);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < int'(KEEP_W); i++) n = n + 32'(k[i]);
    return n;
  endfunction

  // Bytes of the open frame are held back until it commits, so dropped frames never count
  always_ff @(posedge eth_clk) begin
    if (sys_rst) begin
      frame_bytes    <= '0;
      tx_frame_cnt   <= '0;
      rx_frame_cnt   <= '0;
      drop_frame_cnt <= '0;
      tx_byte_cnt    <= '0;
    end else begin
      if (do_write) begin
        if (do_commit) begin
          tx_byte_cnt  <= tx_byte_cnt + frame_bytes + keep_bytes(s_axis_tx.tkeep);
          tx_frame_cnt <= tx_frame_cnt + 32'd1;
          frame_bytes  <= '0;
        end else begin
          frame_bytes <= frame_bytes + keep_bytes(s_axis_tx.tkeep);
        end
      end
      if (do_rewind)                    frame_bytes    <= '0;
      if (do_drop_frame)                drop_frame_cnt <= drop_frame_cnt + 32'd1;
      if (rx_avail_c && rd_entry_c[1])  rx_frame_cnt   <= rx_frame_cnt + 32'd1;
    end
  end
`else
  assign tx_frame_cnt   = '0;
  assign rx_frame_cnt   = '0;
  assign drop_frame_cnt = '0;
  assign tx_byte_cnt    = '0;
`endif

endmodule
